bsk_prd_poller: RTL and testbench
=================================

Name: bsk_prd_poller

Overview:
- Bus-master sequencer that polls the two PRD command-receiver units (CS 4'b1011 for commands 16..01, CS 4'b1001 for 32..17) over the shared 16-bit host bus.
- Generates chip-select, address and active-low read/write strobes, and checks each unit's version field.
- Debounces each unit's command word across consecutive polls and presents stable command words to the rest of the BSK logic.
- Sits between the PRD units' bus pins and the command-processing core.

Parameters:
- SETUP_CYC, 1, cycles CS/A are driven before the strobe falls (1..15).
- STROBE_CYC, 3, cycles the strobe is held low (1..15).
- PERIOD_CYC, 1000, cycles between automatic poll starts (>= 64).
- CS_UNIT0, 4'b1011, CS code of unit 0.
- CS_UNIT1, 4'b1001, CS code of unit 1.
- VERSION, 7'h25, expected version in status bits [7:1].

Ports:
- clk  in  1  system clock
- iRes  in  1  synchronous reset, active low
- iEn  in  1  enables periodic polling
- iStart  in  1  one-cycle request for an immediate poll
- iD  in  16  read data from bus
- oD  out  16  write data to bus
- oDOe  out  1  bus drive enable, high during a write access
- oCS  out  4  chip select; 4'b1111 when idle
- oA  out  2  register address
- oRd  out  1  read strobe, active low
- oWr  out  1  write strobe, active low
- oCom0  out  16  debounced command word, unit 0
- oCom1  out  16  debounced command word, unit 1
- oComValid  out  1  one-cycle pulse at end of each poll
- oVerErr  out  2  per-unit version mismatch from last poll
- oBusy  out  1  poll in progress

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: iRes sampled low on a rising clk edge resets all state on that edge.
- Reset values: oCS=4'b1111, oA=0, oRd=1, oWr=1, oDOe=0, oD=0, oCom0=oCom1=0, oComValid=0, oVerErr=0, oBusy=0, FSM=IDLE, period counter=0, pending=0.
- Reset mid-access: strobe and CS release on that same edge, and the access is abandoned.
- Period counter: runs while iEn=1 and wraps at PERIOD_CYC-1; the wrap raises a start request. iEn=0 clears the counter.
- Start requests: iStart or the counter wrap. A request arriving while oBusy=1 sets a one-deep pending flag. The pending poll starts on the first cycle after the current poll ends. Further requests while pending is set are dropped.
- Access sequence per poll: A0 = unit0 read A=11, A1 = unit0 read A=01, A2 = unit1 read A=11, A3 = unit1 read A=01.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (next access: SETUP | last: DONE) -> IDLE.
  - SETUP: lasts SETUP_CYC cycles. oCS and oA valid, strobes high.
  - STROBE: lasts STROBE_CYC cycles. oRd (or oWr) low.
  - HOLD: 1 cycle. Strobe high, CS/A still held.
  - DONE: 1 cycle. oCS=1111, oComValid=1.
- Access length is SETUP_CYC+STROBE_CYC+1 cycles. A default poll takes 4*5+1 = 21 cycles.
- oBusy is high from the first SETUP cycle through DONE.
- Read sampling: iD is registered on the last STROBE cycle of each read.
- Version check: oVerErr[u] = (status[7:1] != VERSION). It updates in DONE.
- Debounce: each unit keeps the previous poll's raw A=01 word. In DONE, oComU loads the new raw word only if it equals the previous raw word; otherwise oComU holds. The previous raw word is then replaced unconditionally. The first poll after reset never updates oCom, because the previous raw word is 0 and only a raw 0 would match.
- iEn falling mid-poll: the current poll completes.
- iStart is honoured regardless of iEn.

Optional Feature:
- Macro: BSK_PRD_POLLER_ECHO_EN.
- When defined: two write accesses are appended after A3, in order unit0 A=10 with oCom0 and unit1 A=10 with oCom1, using the values just committed in this poll. During these accesses oDOe=1 and oD is stable from the first SETUP cycle through HOLD, and oWr pulses low for STROBE_CYC cycles. DONE follows the last write. A default poll then takes 31 cycles.
- When undefined: no write accesses occur, oDOe stays 0 and oD stays 0.

Test Plan:
- Reset held low with iEn=1 for 2000 cycles -> oCS=1111, oRd=oWr=1, oBusy=0, no oComValid.
- iStart pulse with iD fixed at 16'hA44A (status bits[7:1]=7'h25) -> oCS order 1011,1011,1001,1001 with oA 11,01,11,01. Each oRd low exactly 3 cycles. oComValid exactly 21 cycles after the start. oVerErr=00. oCom0 stays 0.
- Two polls with unit0 A=01 returning 16'hE1E1 both times -> oCom0=16'hE1E1 after the second oComValid. With 16'hE1E1 then 16'h0F0F -> oCom0 unchanged.
- Status read returning 16'hA400 for unit1 -> oVerErr=2'b10 at DONE. A correct status on the next poll -> oVerErr=00.
- iStart pulses at cycles 5 and 8 of a poll, then iRes low during STROBE of the next poll -> exactly one back-to-back poll follows. On the reset edge oRd=1 and oCS=1111.
- With BSK_PRD_POLLER_ECHO_EN, after oCom1=16'h1111 is committed -> a write at CS 1001 A=10 with oD=16'h1111, oDOe=1 and oWr low 3 cycles. oComValid at cycle 31.

Source files
------------

// File: rtl/bsk_prd_poller.sv
// Purpose : polls the two PRD command-receiver units over the shared host bus,
//           checks their version field and debounces their command words.
// Latency : one poll = 4 accesses of (SETUP_CYC+STROBE_CYC+1) cycles + 1 DONE
//           cycle (6 accesses when BSK_PRD_POLLER_ECHO_EN is defined).
//           oComValid pulses in DONE.
// Backpressure: none. A request while busy is held in a one-deep pending flag.
//           Any further request while the flag is set is dropped.
// Optional feature macro: BSK_PRD_POLLER_ECHO_EN. When defined, the committed
//           command words are written back to each unit at A=10.
// Ports   : clk, iRes (sync, active low), iEn (periodic polling),
//           iStart (immediate poll), iD/oD/oDOe (bus data),
//           oCS/oA/oRd/oWr (bus control), oCom0/oCom1 (debounced commands),
//           oComValid (end-of-poll pulse), oVerErr (per-unit version error),
//           oBusy (poll in progress).
module bsk_prd_poller #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 3,
   parameter int unsigned PERIOD_CYC = 1000,
   parameter logic [3:0]  CS_UNIT0   = 4'b1011,
   parameter logic [3:0]  CS_UNIT1   = 4'b1001,
   parameter logic [6:0]  VERSION    = 7'h25
) (
   input  logic        clk,
   input  logic        iRes,
   input  logic        iEn,
   input  logic        iStart,
   input  logic [15:0] iD,
   output logic [15:0] oD,
   output logic        oDOe,
   output logic [3:0]  oCS,
   output logic [1:0]  oA,
   output logic        oRd,
   output logic        oWr,
   output logic [15:0] oCom0,
   output logic [15:0] oCom1,
   output logic        oComValid,
   output logic [1:0]  oVerErr,
   output logic        oBusy
);

`ifdef BSK_PRD_POLLER_ECHO_EN
   localparam logic [2:0] LAST_ACC = 3'd5;
`else
   localparam logic [2:0] LAST_ACC = 3'd3;
`endif

   localparam int PW = $clog2(PERIOD_CYC);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    ph_cnt, ph_cnt_nxt;
   logic [2:0]    acc, acc_nxt;

   logic [PW-1:0] per_cnt;
   logic          pending;
   logic          wrap, req, busy, start_now;

   logic [6:0]    stat0, stat1;
   logic [15:0]   raw0, raw1, prev0, prev1;
   logic [15:0]   com0, com1;
   logic [15:0]   com0_nxt, com1_nxt;
   logic [1:0]    ver_err;

   logic          strobe_last;
   logic          is_write;
   logic          is_unit1;

   assign wrap      = iEn && (per_cnt == PW'(PERIOD_CYC - 1));
   assign req       = iStart || wrap;
   assign busy      = (state != IDLE);
   // A new poll may begin from IDLE or straight out of DONE (back-to-back).
   assign start_now = ((state == IDLE) || (state == DONE)) && (req || pending);

   assign strobe_last = (state == STROBE) && (ph_cnt == 4'(STROBE_CYC - 1));
   // Accesses 0..3 are reads; 4 and 5 (echo build only) are writes.
   assign is_write    = acc[2];
   assign is_unit1    = (acc == 3'd2) || (acc == 3'd3) || (acc == 3'd5);

   // Value each unit's command word takes at DONE; also the echo write data,
   // which is stable for the whole write access since raw/prev/com are static.
   assign com0_nxt = (raw0 == prev0) ? raw0 : com0;
   assign com1_nxt = (raw1 == prev1) ? raw1 : com1;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!iRes) begin
         state  <= IDLE;
         ph_cnt <= 4'd0;
         acc    <= 3'd0;
      end else begin
         state  <= state_nxt;
         ph_cnt <= ph_cnt_nxt;
         acc    <= acc_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt  = state;
      ph_cnt_nxt = ph_cnt;
      acc_nxt    = acc;
      case (state)
         IDLE: begin
            if (start_now) begin
               state_nxt  = SETUP;
               ph_cnt_nxt = 4'd0;
               acc_nxt    = 3'd0;
            end
         end
         SETUP: begin
            if (ph_cnt == 4'(SETUP_CYC - 1)) begin
               state_nxt  = STROBE;
               ph_cnt_nxt = 4'd0;
            end else begin
               ph_cnt_nxt = ph_cnt + 4'd1;
            end
         end
         STROBE: begin
            if (strobe_last) begin
               state_nxt  = HOLD;
               ph_cnt_nxt = 4'd0;
            end else begin
               ph_cnt_nxt = ph_cnt + 4'd1;
            end
         end
         HOLD: begin
            if (acc == LAST_ACC) begin
               state_nxt = DONE;
            end else begin
               state_nxt  = SETUP;
               ph_cnt_nxt = 4'd0;
               acc_nxt    = acc + 3'd1;
            end
         end
         DONE: begin
            if (start_now) begin
               state_nxt  = SETUP;
               ph_cnt_nxt = 4'd0;
               acc_nxt    = 3'd0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      oCS       = 4'b1111;
      oA        = 2'b00;
      oRd       = 1'b1;
      oWr       = 1'b1;
      oDOe      = 1'b0;
      oD        = 16'h0000;
      oComValid = 1'b0;
      oBusy     = busy;
      if ((state == SETUP) || (state == STROBE) || (state == HOLD)) begin
         oCS = is_unit1 ? CS_UNIT1 : CS_UNIT0;
         // Status lives at A=11, command word at A=01, echo target at A=10.
         oA  = is_write ? 2'b10 : (acc[0] ? 2'b01 : 2'b11);
         if (state == STROBE) begin
            if (is_write) oWr = 1'b0;
            else          oRd = 1'b0;
         end
`ifdef BSK_PRD_POLLER_ECHO_EN
         if (is_write) begin
            oDOe = 1'b1;
            oD   = is_unit1 ? com1_nxt : com0_nxt;
         end
`endif
      end else if (state == DONE) begin
         oComValid = 1'b1;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!iRes) begin
         per_cnt <= '0;
         pending <= 1'b0;
         stat0   <= 7'd0;
         stat1   <= 7'd0;
         raw0    <= 16'd0;
         raw1    <= 16'd0;
         prev0   <= 16'd0;
         prev1   <= 16'd0;
         com0    <= 16'd0;
         com1    <= 16'd0;
         ver_err <= 2'b00;
      end else begin
         if (!iEn || wrap) per_cnt <= '0;
         else              per_cnt <= per_cnt + PW'(1);

         if (start_now)         pending <= 1'b0;
         else if (busy && req)  pending <= 1'b1;

         if (strobe_last && !is_write) begin
            case (acc)
               3'd0:    stat0 <= iD[7:1];
               3'd1:    raw0  <= iD;
               3'd2:    stat1 <= iD[7:1];
               default: raw1  <= iD;
            endcase
         end

         if (state == DONE) begin
            ver_err <= {(stat1 != VERSION), (stat0 != VERSION)};
            com0    <= com0_nxt;
            com1    <= com1_nxt;
            prev0   <= raw0;
            prev1   <= raw1;
         end
      end
   end

   assign oCom0   = com0;
   assign oCom1   = com1;
   assign oVerErr = ver_err;

endmodule

// File: tb/tb_bsk_prd_poller.sv
// Purpose : directed self-checking bench for bsk_prd_poller.
// Latency : not applicable (bench).
// Backpressure: not applicable (bench); a small bus model answers reads.
module tb_bsk_prd_poller;

   localparam int ACC_LEN = 5;
`ifdef BSK_PRD_POLLER_ECHO_EN
   localparam int NACC = 6;
`else
   localparam int NACC = 4;
`endif
   localparam int PLEN = NACC * ACC_LEN + 1;

   logic        clk;
   logic        iRes, iEn, iStart;
   logic [15:0] iD, oD;
   logic        oDOe;
   logic [3:0]  oCS;
   logic [1:0]  oA;
   logic        oRd, oWr;
   logic [15:0] oCom0, oCom1;
   logic        oComValid;
   logic [1:0]  oVerErr;
   logic        oBusy;

   // Register contents the bus model returns for each unit.
   logic [15:0] st0, cm0, st1, cm1;

   int n_checks = 0;
   int n_errors = 0;

   bsk_prd_poller dut (
      .clk       (clk),
      .iRes      (iRes),
      .iEn       (iEn),
      .iStart    (iStart),
      .iD        (iD),
      .oD        (oD),
      .oDOe      (oDOe),
      .oCS       (oCS),
      .oA        (oA),
      .oRd       (oRd),
      .oWr       (oWr),
      .oCom0     (oCom0),
      .oCom1     (oCom1),
      .oComValid (oComValid),
      .oVerErr   (oVerErr),
      .oBusy     (oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      iD = 16'h0000;
      if      (oCS == 4'b1011 && oA == 2'b11) iD = st0;
      else if (oCS == 4'b1011 && oA == 2'b01) iD = cm0;
      else if (oCS == 4'b1001 && oA == 2'b11) iD = st1;
      else if (oCS == 4'b1001 && oA == 2'b01) iD = cm1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one iStart and compare every cycle of the poll against the
   // expected bus trace, then the committed results.
   task automatic do_poll(input string tag, input logic [15:0] ec0,
                          input logic [15:0] ec1, input logic [1:0] ever);
      int bad, rdlow, vld_at, k, ph;
      logic [3:0]  ecs;
      logic [1:0]  ea;
      logic [15:0] ed;
      logic        erd, ewr, eoe, evld, ebusy;
      bad = 0; rdlow = 0; vld_at = -1;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int c = 1; c <= PLEN + 1; c++) begin
         k  = (c - 1) / ACC_LEN;
         ph = (c - 1) % ACC_LEN;
         if (c < PLEN) begin
            ecs   = (k == 0 || k == 1 || k == 4) ? 4'b1011 : 4'b1001;
            ea    = (k >= 4) ? 2'b10 : ((k % 2 == 0) ? 2'b11 : 2'b01);
            erd   = !(k < 4 && ph >= 1 && ph <= 3);
            ewr   = !(k >= 4 && ph >= 1 && ph <= 3);
            eoe   = (k >= 4);
            ed    = (k == 4) ? ec0 : ((k == 5) ? ec1 : 16'h0000);
            evld  = 1'b0;
            ebusy = 1'b1;
            if (oA !== ea) bad++;
         end else begin
            ecs   = 4'b1111;
            erd   = 1'b1;
            ewr   = 1'b1;
            eoe   = 1'b0;
            ed    = 16'h0000;
            evld  = (c == PLEN);
            ebusy = (c == PLEN);
         end
         if (oCS !== ecs || oRd !== erd || oWr !== ewr || oDOe !== eoe ||
             oD !== ed || oComValid !== evld || oBusy !== ebusy) bad++;
         if (oRd === 1'b0) rdlow++;
         if (oComValid === 1'b1 && vld_at < 0) vld_at = c;
         tick();
      end
      chk({tag, "_trace_bad_cycles"}, bad, 0);
      chk({tag, "_rd_low_cycles"}, rdlow, 12);
      chk({tag, "_valid_cycle"}, vld_at, PLEN);
      chk({tag, "_com0"}, oCom0, ec0);
      chk({tag, "_com1"}, oCom1, ec1);
      chk({tag, "_ver_err"}, oVerErr, ever);
   endtask

   initial begin
      int bad, vcount, first, second, b999, b1000;
      logic busy_after;
      iRes = 1'b0; iEn = 1'b1; iStart = 1'b0;
      st0 = 16'hA44A; cm0 = 16'hA44A; st1 = 16'hA44A; cm1 = 16'hA44A;

      // Long reset with polling enabled: bus must stay idle.
      bad = 0;
      repeat (2000) begin
         tick();
         if (oCS !== 4'b1111 || oRd !== 1'b1 || oWr !== 1'b1 || oBusy !== 1'b0 ||
             oComValid !== 1'b0 || oDOe !== 1'b0) bad++;
      end
      chk("reset_hold_bad_cycles", bad, 0);
      chk("reset_cs", oCS, 4'b1111);
      chk("reset_a", oA, 2'b00);
      chk("reset_d", oD, 16'h0000);
      chk("reset_com0", oCom0, 16'h0000);
      chk("reset_ver_err", oVerErr, 2'b00);

      iEn = 1'b0;
      iRes = 1'b1;
      tick();
      tick();

      // First poll never commits; version good.
      do_poll("p1", 16'h0000, 16'h0000, 2'b00);
      cm0 = 16'hE1E1;
      do_poll("p2", 16'h0000, 16'hA44A, 2'b00);
      cm1 = 16'h1111;
      do_poll("p3", 16'hE1E1, 16'hA44A, 2'b00);
      cm0 = 16'h0F0F; st1 = 16'hA400;
      do_poll("p4", 16'hE1E1, 16'h1111, 2'b10);
      st1 = 16'hA44A;
      do_poll("p5", 16'h0F0F, 16'h1111, 2'b00);

      // Two requests during a poll produce exactly one back-to-back poll.
      iStart = 1'b1;
      tick();
      vcount = 0; first = -1; second = -1; busy_after = 1'b0;
      for (int c = 1; c <= 3 * PLEN; c++) begin
         iStart = (c == 5 || c == 8);
         if (oComValid === 1'b1) begin
            vcount++;
            if (first < 0) first = c;
            else           second = c;
         end
         if (c == PLEN + 1) busy_after = oBusy;
         tick();
      end
      iStart = 1'b0;
      chk("pend_valid_count", vcount, 2);
      chk("pend_first_valid", first, PLEN);
      chk("pend_second_valid", second, 2 * PLEN);
      chk("pend_busy_after_done", busy_after, 1'b1);

      // Same, but reset lands in the STROBE of the back-to-back poll.
      iStart = 1'b1;
      tick();
      vcount = 0;
      for (int c = 1; c <= PLEN + 2; c++) begin
         iStart = (c == 5 || c == 8);
         if (oComValid === 1'b1) vcount++;
         if (c == PLEN + 2) begin
            chk("b2b_rd_low", oRd, 1'b0);
            chk("b2b_cs", oCS, 4'b1011);
            iRes = 1'b0;
         end
         tick();
      end
      iStart = 1'b0;
      chk("mid_rst_valid_count", vcount, 1);
      chk("mid_rst_rd", oRd, 1'b1);
      chk("mid_rst_cs", oCS, 4'b1111);
      chk("mid_rst_busy", oBusy, 1'b0);
      chk("mid_rst_com0", oCom0, 16'h0000);
      iRes = 1'b1;
      bad = 0;
      repeat (60) begin
         tick();
         if (oBusy !== 1'b0) bad++;
      end
      chk("post_rst_busy_cycles", bad, 0);

      // Periodic start; iEn drops mid-poll and the poll still completes.
      iEn = 1'b1;
      b999 = -1; b1000 = -1; first = -1;
      for (int c = 1; c <= 1000 + PLEN; c++) begin
         tick();
         if (c == 999)  b999 = oBusy;
         if (c == 1000) b1000 = oBusy;
         if (c == 1005) iEn = 1'b0;
         if (oComValid === 1'b1 && first < 0) first = c;
      end
      chk("period_busy_c999", b999, 0);
      chk("period_busy_c1000", b1000, 1);
      chk("period_valid_cycle", first, 1000 + PLEN - 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
